// File: rtl/bl_seq_pkg.sv
// Shared definitions for the bitline segment sequencer: mode codes, FSM states
// and the segment mask helpers that mirror the bl_mask_8_32_1 decoder mapping.
package bl_seq_pkg;

  localparam logic [1:0] CONF_W32  = 2'b00;
  localparam logic [1:0] CONF_W16  = 2'b01;
  localparam logic [1:0] CONF_W8   = 2'b10;
  localparam logic [1:0] CONF_RSVD = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WBEAT,
    ST_RISSUE,
    ST_RCAPT,
    ST_RESP
  } state_t;

  // Index of the last beat (N-1) for a given mode.
  function automatic logic [1:0] beats(input logic [1:0] conf);
    case (conf)
      CONF_W16: beats = 2'd1;
      CONF_W8:  beats = 2'd3;
      default:  beats = 2'd0;
    endcase
  endfunction

  function automatic logic [31:0] seg_mask(input logic [1:0] conf, input logic [1:0] idx);
    case (conf)
      CONF_W32: seg_mask = 32'hFFFF_FFFF;
      CONF_W16: seg_mask = idx[0] ? 32'hFFFF_0000 : 32'h0000_FFFF;
      CONF_W8:  seg_mask = 32'h0000_00FF << {idx, 3'b000};
      default:  seg_mask = 32'h0000_0000;
    endcase
  endfunction

endpackage

// File: rtl/bl_seq_ctrl.sv
// Host-to-array sequencer: splits one 32-bit request into 1/2/4 masked beats
// through the bitline mask decoder and reassembles read data into one response.
module bl_seq_ctrl
  import bl_seq_pkg::*;
#(
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        conf_in,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic              sram_en,
  output logic              sram_we,
  output logic [ADDR_W-1:0] sram_row,
  output logic [31:0]       sram_wdata,
  input  logic [31:0]       sram_rdata,
  output logic [1:0]        mask_addr,
  output logic [1:0]        mask_conf
);

  state_t              r_state;
  state_t              w_state_next;
  logic                r_init;
  logic                r_we;
  logic                r_err;
  logic [ADDR_W-1:0]   r_row;
  logic [31:0]         r_wdata;
  logic [31:0]         r_asm;
  logic [1:0]          r_conf;
  logic [1:0]          r_cnt;
  logic                w_accept;
  logic                w_last;
  logic [31:0]         w_mask;

  // r_init keeps req_ready low until the first edge after reset release.
  assign w_accept = (r_state == ST_IDLE) && r_init && req_valid;
  assign w_last   = (r_cnt == beats(r_conf));
  assign w_mask   = seg_mask(r_conf, r_cnt);

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          if (conf_in == CONF_RSVD) w_state_next = ST_RESP;
          else if (req_we)          w_state_next = ST_WBEAT;
          else                      w_state_next = ST_RISSUE;
        end
      end
      ST_WBEAT:  if (w_last) w_state_next = ST_RESP;
      ST_RISSUE: w_state_next = ST_RCAPT;
      ST_RCAPT:  w_state_next = w_last ? ST_RESP : ST_RISSUE;
      ST_RESP:   if (resp_ready) w_state_next = ST_IDLE;
      default:   w_state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    req_ready  = 1'b0;
    sram_en    = 1'b0;
    sram_we    = 1'b0;
    mask_addr  = 2'd0;
    resp_valid = 1'b0;
    resp_rdata = 32'd0;
    case (r_state)
      ST_IDLE:   req_ready = r_init;
      ST_WBEAT: begin
        sram_en   = 1'b1;
        sram_we   = 1'b1;
        mask_addr = r_cnt;
      end
      ST_RISSUE: begin
        sram_en   = 1'b1;
        mask_addr = r_cnt;
      end
      ST_RESP: begin
        resp_valid = 1'b1;
        resp_rdata = r_asm;
      end
      default: ;
    endcase
  end

  assign resp_err   = r_err;
  assign sram_row   = r_row;
  assign sram_wdata = r_wdata;
  assign mask_conf  = r_conf;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_init  <= 1'b0;
      r_we    <= 1'b0;
      r_err   <= 1'b0;
      r_row   <= '0;
      r_wdata <= 32'd0;
      r_asm   <= 32'd0;
      r_conf  <= 2'd0;
      r_cnt   <= 2'd0;
    end else begin
      r_state <= w_state_next;
      r_init  <= 1'b1;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_we    <= req_we;
            r_row   <= req_addr;
            r_wdata <= req_wdata;
            r_conf  <= conf_in;
            r_cnt   <= 2'd0;
            r_err   <= (conf_in == CONF_RSVD);
          end
        end
        ST_WBEAT: r_cnt <= r_cnt + 2'd1;
        ST_RCAPT: begin
          // Merge only this beat's segment; sense-amp bits elsewhere are don't-care.
          r_asm <= (r_asm & ~w_mask) | (sram_rdata & w_mask);
          r_cnt <= r_cnt + 2'd1;
        end
        ST_RESP: begin
          if (resp_ready) begin
            r_asm <= 32'd0;
            r_err <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bl_seq_ctrl.sv
// Directed bench for bl_seq_ctrl: a transaction-level timeline model checked
// every cycle, plus literal latency/data/beat expectations per request.
module tb_bl_seq_ctrl;

  localparam int ADDR_W = 5;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic [1:0]        conf_in;
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              resp_valid;
  logic              resp_ready;
  logic [31:0]       resp_rdata;
  logic              resp_err;
  logic              sram_en;
  logic              sram_we;
  logic [ADDR_W-1:0] sram_row;
  logic [31:0]       sram_wdata;
  logic [31:0]       sram_rdata = 32'd0;
  logic [1:0]        mask_addr;
  logic [1:0]        mask_conf;

  always #5 clk = ~clk;

  bl_seq_ctrl #(.ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .conf_in    (conf_in),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .sram_en    (sram_en),
    .sram_we    (sram_we),
    .sram_row   (sram_row),
    .sram_wdata (sram_wdata),
    .sram_rdata (sram_rdata),
    .mask_addr  (mask_addr),
    .mask_conf  (mask_conf)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Segment of width 32>>conf at position idx.
  function automatic logic [31:0] tb_mask(input logic [1:0] conf, input logic [1:0] idx);
    int w;
    if (conf == 2'b11) return 32'd0;
    w = 32 >> conf;
    if (w == 32) return 32'hFFFF_FFFF;
    return ((32'd1 << w) - 32'd1) << (w * int'(idx));
  endfunction

  // Array model: masked writes; reads return the addressed segment, all-ones elsewhere.
  logic [31:0] sram_arr [32];
  always @(posedge clk) begin
    if (sram_en) begin
      if (sram_we)
        sram_arr[sram_row] <= (sram_arr[sram_row] & ~tb_mask(mask_conf, mask_addr))
                              | (sram_wdata & tb_mask(mask_conf, mask_addr));
      else
        sram_rdata <= (sram_arr[sram_row] & tb_mask(mask_conf, mask_addr))
                      | ~tb_mask(mask_conf, mask_addr);
    end
  end

  // Timeline model: phase 0 idle, 1 beats (m_c = cycle since acceptance), 2 response.
  int          m_phase = 0;
  int          m_c = 0;
  int          m_n = 0;
  logic        m_ready_ok = 1'b0;
  logic        m_we = 1'b0;
  logic        m_err = 1'b0;
  logic [1:0]  m_conf = 2'd0;
  logic [4:0]  m_row = 5'd0;
  logic [31:0] m_wdata = 32'd0;
  logic [31:0] m_rdata = 32'd0;
  logic [31:0] ref_mem [32];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase    <= 0;
      m_c        <= 0;
      m_ready_ok <= 1'b0;
      m_we       <= 1'b0;
      m_err      <= 1'b0;
      m_conf     <= 2'd0;
      m_row      <= 5'd0;
      m_wdata    <= 32'd0;
      m_rdata    <= 32'd0;
    end else begin
      m_ready_ok <= 1'b1;
      case (m_phase)
        0: if (m_ready_ok && req_valid) begin
          m_we    <= req_we;
          m_conf  <= conf_in;
          m_row   <= req_addr;
          m_wdata <= req_wdata;
          m_c     <= 1;
          if (conf_in == 2'b11) begin
            m_phase <= 2;
            m_err   <= 1'b1;
            m_rdata <= 32'd0;
          end else begin
            m_phase <= 1;
            m_err   <= 1'b0;
            m_n     <= 1 << conf_in;
            if (req_we) begin
              ref_mem[req_addr] <= req_wdata;
              m_rdata <= 32'd0;
            end else begin
              m_rdata <= ref_mem[req_addr];
            end
          end
        end
        1: if (m_c == (m_we ? m_n : 2 * m_n)) m_phase <= 2;
           else m_c <= m_c + 1;
        2: if (resp_ready) m_phase <= 0;
        default: m_phase <= 0;
      endcase
    end
  end

  logic       e_ready, e_en, e_valid;
  logic [1:0] e_ma;
  assign e_ready = (m_phase == 0) && m_ready_ok;
  assign e_en    = (m_phase == 1) && (m_we || (m_c % 2 == 1));
  assign e_ma    = !e_en ? 2'd0 : (m_we ? 2'(m_c - 1) : 2'((m_c - 1) / 2));
  assign e_valid = (m_phase == 2);

  always @(negedge clk) begin
    chk("req_ready",  32'(req_ready),  32'(e_ready));
    chk("sram_en",    32'(sram_en),    32'(e_en));
    chk("sram_we",    32'(sram_we),    32'(e_en && m_we));
    chk("mask_addr",  32'(mask_addr),  32'(e_ma));
    chk("mask_conf",  32'(mask_conf),  32'(m_conf));
    chk("sram_row",   32'(sram_row),   32'(m_row));
    chk("sram_wdata", sram_wdata,      m_wdata);
    chk("resp_valid", 32'(resp_valid), 32'(e_valid));
    if (e_valid) begin
      chk("resp_rdata", resp_rdata,      m_rdata);
      chk("resp_err",   32'(resp_err),   32'(m_err));
    end
  end

  logic [1:0] beat_q [$];
  always @(negedge clk) if (sram_en) beat_q.push_back(mask_addr);

  task automatic do_req(input string tag, input logic we, input logic [1:0] conf,
                        input logic [4:0] row, input logic [31:0] wd, input int hold,
                        input int exp_lat, input logic [31:0] exp_rd, input logic exp_err,
                        input int exp_beats);
    int k;
    logic got;
    logic [31:0] held;
    @(negedge clk);
    beat_q.delete();
    req_valid  = 1'b1;
    req_we     = we;
    conf_in    = conf;
    req_addr   = row;
    req_wdata  = wd;
    resp_ready = (hold == 0);
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (req_ready) begin got = 1'b1; break; end
      @(negedge clk);
    end
    chk({tag, " accept"}, 32'(got), 32'd1);
    if (!got) begin
      req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    @(negedge clk);
    k = 1;
    if (hold == 0) req_valid = 1'b0;
    else req_addr = row + 5'd1;
    got = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (resp_valid) begin got = 1'b1; break; end
      @(negedge clk);
      k++;
    end
    chk({tag, " resp seen"}, 32'(got), 32'd1);
    chk({tag, " latency"}, 32'(k), 32'(exp_lat));
    chk({tag, " rdata"}, resp_rdata, exp_rd);
    chk({tag, " err"}, 32'(resp_err), 32'(exp_err));
    chk({tag, " beats"}, 32'(beat_q.size()), 32'(exp_beats));
    for (int j = 0; j < beat_q.size() && j < exp_beats; j++)
      chk({tag, " beat idx"}, 32'(beat_q[j]), 32'(j));
    if (hold > 0) begin
      held = resp_rdata;
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        chk({tag, " hold valid"}, 32'(resp_valid), 32'd1);
        chk({tag, " hold rdata"}, resp_rdata, held);
        chk({tag, " hold ready"}, 32'(req_ready), 32'd0);
      end
      req_valid  = 1'b0;
      resp_ready = 1'b1;
    end
    $display("%s: we=%0d conf=%0d row=%0d latency=%0d rdata=%h err=%0d beats=%0d",
             tag, we, conf, row, k, resp_rdata, resp_err, beat_q.size());
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit got;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_addr   = '0;
    req_wdata  = 32'd0;
    conf_in    = 2'd0;
    resp_ready = 1'b1;
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset req_ready", 32'(req_ready), 32'd0);
    chk("reset resp_valid", 32'(resp_valid), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready one edge after release", 32'(req_ready), 32'd1);

    do_req("w32 row3",   1'b1, 2'b00, 5'd3, 32'hDEADBEEF, 0, 2, 32'h0,        1'b0, 1);
    do_req("w8 row7",    1'b1, 2'b10, 5'd7, 32'h44332211, 0, 5, 32'h0,        1'b0, 4);
    do_req("r8 row7",    1'b0, 2'b10, 5'd7, 32'h0,        0, 9, 32'h44332211, 1'b0, 4);
    do_req("w16 hold",   1'b1, 2'b01, 5'd9, 32'hCAFEF00D, 5, 3, 32'h0,        1'b0, 2);
    do_req("r16 row9",   1'b0, 2'b01, 5'd9, 32'h0,        0, 5, 32'hCAFEF00D, 1'b0, 2);
    do_req("r32 row3",   1'b0, 2'b00, 5'd3, 32'h0,        0, 3, 32'hDEADBEEF, 1'b0, 1);
    do_req("rsvd read",  1'b0, 2'b11, 5'd1, 32'h0,        0, 1, 32'h0,        1'b1, 0);
    do_req("r32 row9",   1'b0, 2'b00, 5'd9, 32'h0,        0, 3, 32'hCAFEF00D, 1'b0, 1);
    do_req("r8 row3",    1'b0, 2'b10, 5'd3, 32'h0,        0, 9, 32'hDEADBEEF, 1'b0, 4);

    // Mode-10 read with a mid-transaction conf change and reset pulse.
    @(negedge clk);
    beat_q.delete();
    req_valid = 1'b1;
    req_we    = 1'b0;
    conf_in   = 2'b10;
    req_addr  = 5'd7;
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (req_ready) begin got = 1'b1; break; end
      @(negedge clk);
    end
    chk("rst-test accept", 32'(got), 32'd1);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    conf_in = 2'b00;
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async rst sram_en",    32'(sram_en),    32'd0);
    chk("async rst req_ready",  32'(req_ready),  32'd0);
    chk("async rst resp_valid", 32'(resp_valid), 32'd0);
    chk("async rst mask_addr",  32'(mask_addr),  32'd0);
    chk("async rst mask_conf",  32'(mask_conf),  32'd0);
    chk("async rst sram_row",   32'(sram_row),   32'd0);
    chk("async rst sram_wdata", sram_wdata,      32'd0);
    chk("rst-test beats before reset", 32'(beat_q.size()), 32'd2);
    for (int j = 0; j < beat_q.size() && j < 2; j++)
      chk("rst-test beat idx", 32'(beat_q[j]), 32'(j));
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    chk("rst-test ready at release", 32'(req_ready), 32'd0);
    @(negedge clk);
    chk("rst-test ready after edge", 32'(req_ready), 32'd1);
    repeat (3) @(negedge clk);
    chk("rst-test no beats after reset", 32'(beat_q.size()), 32'd2);
    $display("rst-test: beats before reset=%0d req_ready=%0d", beat_q.size(), req_ready);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/bl_seq_ctrl.md
# bl_seq_ctrl

Sequences column-segmented accesses to one 32-bit-wide SRAM row through the bitline mask decoder `bl_mask_8_32_1`. It accepts 32-bit host read/write requests over a valid/ready handshake and latches the width configuration. It then issues 1, 2 or 4 masked array beats (32/16/8-bit segment mode), driving the mask decoder's `addr`/`conf` each beat, and reassembles read data before returning one response.

## Interface
- `ADDR_W`, default 5: row address width.
- `clk` input 1: clock, rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `conf_in` input 2: segment mode (00 = 32-bit, 01 = 16-bit, 10 = 8-bit, 11 = reserved); sampled only on request acceptance.
- `req_valid` input 1: request valid.
- `req_ready` output 1: controller idle and able to accept.
- `req_we` input 1: 1 = write, 0 = read.
- `req_addr` input ADDR_W: row address.
- `req_wdata` input 32: write data.
- `resp_valid` output 1: response valid; held until `resp_ready`.
- `resp_ready` input 1: response accepted.
- `resp_rdata` output 32: assembled read data; 0 for writes.
- `resp_err` output 1: set when the request carried `conf_in` = 11.
- `sram_en` output 1: array access strobe, one cycle per beat.
- `sram_we` output 1: beat is a write.
- `sram_row` output ADDR_W: row for the current beat.
- `sram_wdata` output 32: equals latched `req_wdata` for the whole transaction.
- `sram_rdata` input 32: sense-amp data, valid the cycle after `sram_en` with `sram_we` = 0.
- `mask_addr` output 2: segment index to the mask decoder.
- `mask_conf` output 2: latched mode to the mask decoder.

## Operation
- Segment map of the mask decoder:
  - Mode 00: one segment, bits [31:0].
  - Mode 01: segment k = bits [16k+15:16k], k in 0..1.
  - Mode 10: segment k = bits [8k+7:8k], k in 0..3.
- Beat count N: 1, 2 or 4 for modes 00, 01, 10. `mask_addr` steps 0..N-1 in ascending order.
- FSM states: IDLE, WBEAT, RISSUE, RCAPT, RESP.
- IDLE:
  - `req_ready` = 1.
  - On `req_valid & req_ready`, latch `req_we`, `req_addr`, `req_wdata`, `conf_in` and clear the beat counter.
  - If conf = 11, go to RESP with `resp_err` = 1 and no array access.
  - Otherwise go to WBEAT for writes, RISSUE for reads.
- WBEAT:
  - Drive `sram_en` = 1, `sram_we` = 1, `mask_addr` = counter.
  - Increment the counter. After beat N-1, go to RESP.
- RISSUE: drive `sram_en` = 1, `sram_we` = 0, `mask_addr` = counter, then go to RCAPT.
- RCAPT:
  - Copy the current segment's bits of `sram_rdata` into the assembly register; leave other bits unchanged.
  - Increment the counter. Return to RISSUE, or go to RESP after beat N-1.
- RESP: `resp_valid` = 1. On `resp_ready`, clear the assembly register and `resp_err`, then return to IDLE.
- Outside active beats, `sram_en` = 0 and `mask_addr` = 0. `mask_conf` always equals the latched conf.

## Timing
- Reset (async, `rst_n` low): state IDLE, all outputs 0 including `req_ready`, assembly register 0. `req_ready` rises on the first clock edge after `rst_n` deasserts.
- Request accepted at edge E:
  - Write: beats occupy cycles E+1..E+N; `resp_valid` from E+N+1.
  - Read: issue beats at E+1, E+3, ...; `resp_valid` from E+2N+1.
  - Error: `resp_valid` from E+1.
- `req_ready` is 0 from the cycle after acceptance until the cycle after the response handshake. There is no back-to-back overlap.
- A `conf_in` change mid-transaction has no effect until the next acceptance.
- `resp_valid` stays high with stable `resp_rdata`/`resp_err` while `resp_ready` = 0.
- Reset asserted mid-transaction aborts immediately: no further `sram_en` and no response.

## Structure
- Shared package `bl_seq_pkg`:
  - Mode localparams `CONF_W32`, `CONF_W16`, `CONF_W8`, `CONF_RSVD`.
  - State enum.
  - Function `beats(conf)` returning N-1.
  - Function `seg_mask(conf, idx)` returning the 32-bit segment mask used for read assembly; it matches the decoder mapping.
- No sub-module. `bl_mask_8_32_1` is instantiated beside this block at the array top level, wired to `mask_addr`/`mask_conf`.

## Test plan
- Mode 00 write to row 3 with data 0xDEADBEEF, `resp_ready` = 1:
  - One `sram_en` cycle with `mask_addr` = 0, `mask_conf` = 00.
  - `resp_valid` at E+2, `resp_rdata` = 0.
- Mode 10 read of row 7, model returning 0x11 / 0x22 / 0x33 / 0x44 in the addressed byte of each beat (other bytes 0xFF):
  - Four issues with `mask_addr` 0, 1, 2, 3.
  - `resp_rdata` = 0x44332211 at E+9.
- Mode 01 write with `resp_ready` held 0 for 5 cycles:
  - Two beats, `mask_addr` 0 then 1.
  - `resp_valid` held stable; `req_valid` ignored until handshake.
- `conf_in` = 11 read: no `sram_en`; `resp_err` = 1 at E+1; next request's `resp_err` = 0.
- Mode 10 read: flip `conf_in` to 00 at E+2, then pulse `rst_n` low at E+4:
  - Beats continue in mode 10 until the reset pulse.
  - Outputs go to 0 asynchronously on reset.
  - `req_ready` returns 1 one edge after release.
